// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with start/busy/done handshake.
// The result register holds the last product while the next multiply runs.
module shift_add_mult_ctrl #(
  parameter  int MCAND_W = 7,
  parameter  int MPLR_W  = 4,
  localparam int PROD_W  = MCAND_W + MPLR_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [MCAND_W-1:0] mcand,
  input  logic [MPLR_W-1:0]  mplr,
  output logic               busy,
  output logic               done,
  output logic [PROD_W-1:0]  product
);

  localparam int CNT_W = (MPLR_W > 1) ? $clog2(MPLR_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 c_q, c_d;
  logic [MCAND_W-1:0]   a_q, a_d;
  logic [MPLR_W-1:0]    q_q, q_d;
  logic [MCAND_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PROD_W-1:0]    prod_q, prod_d;

  logic [MCAND_W:0]     sum;
  logic [PROD_W+1:0]    shifted;

  // C is always 0 at the start of a step (the shift clears it), so {C,A}
  // is the same as {0,A}; reading it keeps the classic {C,A}+M datapath.
  assign sum     = {c_q, a_q} + (q_q[0] ? {1'b0, m_q} : '0);
  assign shifted = {1'b0, sum, q_q} >> 1;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      c_q     <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          q_d     = mplr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        c_d     = 1'b0;
        a_d     = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        c_d   = shifted[PROD_W];
        a_d   = shifted[PROD_W-1:MPLR_W];
        q_d   = shifted[MPLR_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MPLR_W - 1)) begin
          prod_d  = shifted[PROD_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          m_d     = mcand;
          q_d     = mplr;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == LOAD) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed cases plus random
// start/operand traffic against a cycle-timeline reference model.
module tb_shift_add_mult_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [6:0]  mcand;
  logic [3:0]  mplr;
  logic        busy;
  logic        done;
  logic [10:0] product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: m_age = edges since the accepting edge (0 = idle, 1..5 busy, 6 done).
  int m_age  = 0;
  int m_pend = 0;
  int m_prod = 0;

  always #5 clock = ~clock;

  shift_add_mult_ctrl #(.MCAND_W(7), .MPLR_W(4)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .mcand   (mcand),
    .mplr    (mplr),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if ((m_age == 0 || m_age == 6) && start) begin
      m_age  = 1;
      m_pend = int'(mcand) * int'(mplr);
    end else if (m_age >= 1 && m_age <= 5) begin
      m_age++;
      if (m_age == 6) m_prod = m_pend;
    end else begin
      m_age = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    cyc++;
    check("busy",    32'(busy),    32'(m_age >= 1 && m_age <= 5));
    check("done",    32'(done),    32'(m_age == 6));
    check("product", 32'(product), 32'(m_prod));
  endtask

  task automatic start_op(input int a, input int b, output int acc_cyc);
    mcand = 7'(a);
    mplr  = 4'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_prod, output int done_cyc);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_prod"}, 32'(product), 32'(exp_prod));
    done_cyc = cyc;
  endtask

  initial begin
    int acc, dc, d1, d2;
    clear = 1'b1;
    start = 1'b0;
    mcand = '0;
    mplr  = '0;
    #12;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_product", 32'(product), 32'd0);
    clear = 1'b0;
    tick();

    // Single multiply with latency check.
    start_op(5, 3, acc);
    wait_done("m5x3", 15, dc);
    check("m5x3_latency", 32'(dc - acc), 32'd5);
    tick();

    start_op(127, 15, acc);
    wait_done("m127x15", 1905, dc);
    check("m127x15_latency", 32'(dc - acc), 32'd5);
    tick();
    start_op(0, 9, acc);
    wait_done("m0x9", 0, dc);
    check("m0x9_latency", 32'(dc - acc), 32'd5);
    tick();
    start_op(100, 8, acc);
    wait_done("m100x8", 800, dc);
    check("m100x8_latency", 32'(dc - acc), 32'd5);
    tick();

    // Back-to-back with start held high.
    mcand = 7'd3;
    mplr  = 4'd4;
    start = 1'b1;
    tick();
    wait_done("b2b1", 12, d1);
    mcand = 7'd7;
    mplr  = 4'd2;
    tick();
    start = 1'b0;
    check("b2b_no_idle", 32'(busy), 32'd1);
    wait_done("b2b2", 14, d2);
    check("b2b_spacing", 32'(d2 - d1), 32'd6);
    tick();

    // start toggled during RUN is ignored.
    start_op(9, 9, acc);
    tick();
    mcand = 7'd1;
    mplr  = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_ignore", 81, dc);
    check("busy_ignore_latency", 32'(dc - acc), 32'd5);
    tick();
    check("idle_after_busy", 32'(busy), 32'd0);
    check("idle_after_done", 32'(done), 32'd0);

    // Asynchronous clear in the second RUN cycle.
    start_op(6, 5, acc);
    tick();
    tick();
    #2;
    clear = 1'b1;
    #1;
    m_age  = 0;
    m_pend = 0;
    m_prod = 0;
    check("clr_busy",    32'(busy),    32'd0);
    check("clr_done",    32'(done),    32'd0);
    check("clr_product", 32'(product), 32'd0);
    #2;
    clear = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    start_op(2, 3, acc);
    wait_done("after_clr", 6, dc);
    tick();

    // Random traffic: operands change every cycle, start at random.
    for (int i = 0; i < 400; i++) begin
      mcand = 7'($urandom_range(0, 127));
      mplr  = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 2) != 0);
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
